serv_seqctl: RTL and testbench
==============================

Name: serv_seqctl

Overview:
- Parametrised successor to the bit-serial core state/counter block: instruction sequencer and beat counter for W = 1, 2, 4 or 8 bits per cycle, XLEN = 32 or 64.
- Replaces the shift-register counter and implicit state with an explicit FSM: FETCH, RFREQ, INIT, WAIT, RUN.
- Adds a programmable stall input and a sticky trap cause.
- Sits between the decoder, ibus/dbus, register-file interface and the ALU/bufreg/CSR datapath.

Parameters:
W, 1, datapath bits per cycle; legal 1, 2, 4, 8.
XLEN, 32, architectural width; legal 32, 64.
WITH_CSR, 1, enable trap generation; 0 ties o_ctrl_trap and o_trap_cause to 0.
ALIGN, 0, 1 = no jump-misalign traps (compressed support).
MDU, 0, enable MDU handshake.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_ibus_ack  in  1  instruction fetched
o_ibus_cyc  out  1  fetch request
i_dbus_en  in  1  decoded load/store
i_mem_misalign  in  1  data address misaligned
o_dbus_cyc  out  1  data bus request
i_dbus_ack  in  1  data bus done
i_two_stage_op  in  1  instruction needs INIT pass
i_branch_op, i_cond_branch, i_bne_or_bge, i_alu_cmp  in  1 each  branch decode/compare
i_ctrl_misalign  in  1  jump target misaligned
i_shift_op, i_sh_done  in  1 each  shifter status
i_mdu_op, i_mdu_ready  in  1 each  MDU handshake
o_mdu_valid  out  1  MDU start
i_e_op, i_new_irq  in  1 each  ecall/ebreak, interrupt
i_stall  in  1  freezes counter while counting
o_rf_rreq, o_rf_wreq  out  1 each  RF read/write request (1-cycle pulses)
i_rf_ready  in  1  RF ready
o_init, o_cnt_en, o_cnt_done, o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap  out  1 each  control
o_cnt  out  $clog2(XLEN/W)  beat index
o_cnt0  out  1  beat 0 and counting
o_mem_bytecnt  out  $clog2(XLEN/8)  byte lane = (o_cnt*W)/8
o_trap_cause  out  2  00 none, 01 ecall/irq, 10 jump misalign, 11 mem misalign

Behaviour:
- Reset (async assert, sync release): state=FETCH, o_cnt=0, all other outputs 0 except o_ibus_cyc=1. The fetch is issued the first cycle after release.
- Beats per pass N=XLEN/W. o_cnt_en is 1 in INIT/RUN while !i_stall. o_cnt increments only when o_cnt_en.
- o_cnt_done = o_cnt_en & (o_cnt==N-1). o_cnt wraps to 0 on that beat.
- FETCH:
  - o_ibus_cyc=1.
  - On i_ibus_ack, pulse o_rf_rreq for 1 cycle and go to RFREQ.
- RFREQ: on i_rf_ready, go to INIT if i_two_stage_op & !i_new_irq, else RUN.
- INIT: o_init=1; counts N beats. On o_cnt_done:
  - take_branch = i_branch_op & (!i_cond_branch | (i_alu_cmp ^ i_bne_or_bge)).
  - Latch o_ctrl_jump = take_branch.
  - Latch trap cause: mem misalign if i_dbus_en & i_mem_misalign; else jump misalign if take_branch & i_ctrl_misalign & !ALIGN. Mem misalign has priority.
  - Go to WAIT.
- WAIT:
  - o_dbus_cyc = i_dbus_en & !trap.
  - o_mdu_valid = MDU & i_mdu_op.
  - Exit when trap pending, i_dbus_ack, (MDU & i_mdu_ready), (i_shift_op & i_sh_done), or any other op (first cycle).
  - On exit, pulse o_rf_wreq. If a trap is pending, pulse o_rf_rreq as well. Then go to RFREQ2, which is RFREQ reused with a flag forcing RUN.
- RUN:
  - o_ctrl_pc_en=o_cnt_en.
  - o_ctrl_trap = WITH_CSR & (i_e_op | i_new_irq | cause!=00). On entry with i_e_op|i_new_irq, cause becomes 01 unless already set.
  - On o_cnt_done: go to FETCH, clear cause and o_ctrl_jump.
- i_stall in WAIT/FETCH/RFREQ is ignored.
- i_ibus_ack outside FETCH is ignored.
- i_rf_ready together with o_cnt_done cannot occur; no assertion required.
- Reset mid-pass aborts immediately to FETCH; no RF request is issued.

Test Plan:
1. W=1, XLEN=32, ADD: ack at t0 -> rreq pulse at t1; ready -> RUN 32 beats, o_cnt_done on beat 31, o_ibus_cyc=1 next cycle.
2. W=4, BEQ taken, aligned: INIT 8 beats, o_ctrl_jump=1 in RUN, wreq pulse once, no trap, cause=00.
3. W=8, LW with i_mem_misalign=1: o_dbus_cyc never asserts; rreq+wreq pulse together; o_ctrl_trap=1, cause=11 in RUN.
4. W=2, XLEN=64, i_stall high for 3 cycles at beat 10: o_cnt holds at 10, total RUN = 32+3 cycles.
5. MDU=1, MUL: o_mdu_valid held until i_mdu_ready after 40 cycles -> wreq next cycle, RUN 32 beats.
6. Reset asserted at INIT beat 5: all outputs reset immediately; o_ibus_cyc=1 the cycle after release, o_cnt=0.

Source files
------------

// File: rtl/serv_seqctl.sv
// serv_seqctl: instruction sequencer and beat counter for a W-bit-per-cycle serial core.
// Latency: rf read request one cycle after ibus ack; a pass is XLEN/W beats, plus stall cycles.
// Backpressure: i_stall freezes the beat counter in INIT/RUN; WAIT holds until the bus/MDU/shifter completes.
//
// Ports:
//   i_clk, i_rst_n                   clock, asynchronous active-low reset (release synchronous to i_clk)
//   i_ibus_ack / o_ibus_cyc          instruction fetch handshake
//   i_dbus_en, i_mem_misalign,
//   o_dbus_cyc, i_dbus_ack           data bus handshake
//   decode/status inputs             branch, shift, MDU, ecall/irq, two-stage flags
//   o_rf_rreq, o_rf_wreq, i_rf_ready register-file requests (single-cycle pulses)
//   o_cnt, o_cnt0, o_cnt_en, o_cnt_done, o_mem_bytecnt   beat counter views
//   o_init, o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap, o_trap_cause   datapath control
module serv_seqctl #(
    parameter int W        = 1,
    parameter int XLEN     = 32,
    parameter int WITH_CSR = 1,
    parameter int ALIGN    = 0,
    parameter int MDU      = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_ibus_ack,
    output logic                        o_ibus_cyc,
    input  logic                        i_dbus_en,
    input  logic                        i_mem_misalign,
    output logic                        o_dbus_cyc,
    input  logic                        i_dbus_ack,
    input  logic                        i_two_stage_op,
    input  logic                        i_branch_op,
    input  logic                        i_cond_branch,
    input  logic                        i_bne_or_bge,
    input  logic                        i_alu_cmp,
    input  logic                        i_ctrl_misalign,
    input  logic                        i_shift_op,
    input  logic                        i_sh_done,
    input  logic                        i_mdu_op,
    input  logic                        i_mdu_ready,
    output logic                        o_mdu_valid,
    input  logic                        i_e_op,
    input  logic                        i_new_irq,
    input  logic                        i_stall,
    output logic                        o_rf_rreq,
    output logic                        o_rf_wreq,
    input  logic                        i_rf_ready,
    output logic                        o_init,
    output logic                        o_cnt_en,
    output logic                        o_cnt_done,
    output logic                        o_ctrl_pc_en,
    output logic                        o_ctrl_jump,
    output logic                        o_ctrl_trap,
    output logic [$clog2(XLEN/W)-1:0]   o_cnt,
    output logic                        o_cnt0,
    output logic [$clog2(XLEN/8)-1:0]   o_mem_bytecnt,
    output logic [1:0]                  o_trap_cause
);

    localparam int N  = XLEN / W;
    localparam int CW = $clog2(N);
    localparam int LW = $clog2(W);
    localparam int AW = $clog2(XLEN);
    localparam int BW = $clog2(XLEN / 8);
    localparam bit HAS_CSR  = (WITH_CSR != 0);
    localparam bit HAS_MDU  = (MDU != 0);
    localparam bit NO_ALIGN = (ALIGN == 0);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ECALL = 2'b01;
    localparam logic [1:0] CAUSE_JMPMA = 2'b10;
    localparam logic [1:0] CAUSE_MEMMA = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_RFREQ,
        S_INIT,
        S_WAIT,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            force_run_q, force_run_d;   // RFREQ entered from WAIT: second pass is always RUN
    logic            jump_q, jump_d;
    logic [1:0]      cause_q, cause_d;
    logic            rreq_q, rreq_d;
    logic            wreq_q, wreq_d;

    logic counting, cnt_en, cnt_done, take_branch, trap_pend, other_op, wait_exit;

    assign counting    = (state_q == S_INIT) || (state_q == S_RUN);
    assign cnt_en      = counting && !i_stall;
    assign cnt_done    = cnt_en && (cnt_q == CW'(N - 1));
    assign take_branch = i_branch_op && (!i_cond_branch || (i_alu_cmp ^ i_bne_or_bge));
    assign trap_pend   = (cause_q != CAUSE_NONE);
    // Ops with no completion handshake leave WAIT on their first cycle there.
    assign other_op    = !i_dbus_en && !(HAS_MDU && i_mdu_op) && !i_shift_op;
    assign wait_exit   = trap_pend || i_dbus_ack || (HAS_MDU && i_mdu_ready)
                       || (i_shift_op && i_sh_done) || other_op;

    always_comb begin
        state_d      = state_q;
        force_run_d  = force_run_q;
        jump_d       = jump_q;
        cause_d      = cause_q;
        rreq_d       = 1'b0;
        wreq_d       = 1'b0;
        o_ibus_cyc   = 1'b0;
        o_init       = 1'b0;
        o_dbus_cyc   = 1'b0;
        o_mdu_valid  = 1'b0;
        o_ctrl_pc_en = 1'b0;
        o_ctrl_trap  = 1'b0;
        case (state_q)
            S_FETCH: begin
                o_ibus_cyc = 1'b1;
                if (i_ibus_ack) begin
                    rreq_d  = 1'b1;
                    state_d = S_RFREQ;
                end
            end
            S_RFREQ: begin
                if (i_rf_ready) begin
                    if (!force_run_q && i_two_stage_op && !i_new_irq) begin
                        state_d = S_INIT;
                    end else begin
                        state_d     = S_RUN;
                        force_run_d = 1'b0;
                        if (HAS_CSR && (i_e_op || i_new_irq) && !trap_pend)
                            cause_d = CAUSE_ECALL;
                    end
                end
            end
            S_INIT: begin
                o_init = 1'b1;
                if (cnt_done) begin
                    jump_d  = take_branch;
                    state_d = S_WAIT;
                    if (HAS_CSR) begin
                        if (i_dbus_en && i_mem_misalign)
                            cause_d = CAUSE_MEMMA;
                        else if (take_branch && i_ctrl_misalign && NO_ALIGN)
                            cause_d = CAUSE_JMPMA;
                    end
                end
            end
            S_WAIT: begin
                o_dbus_cyc  = i_dbus_en && !trap_pend;
                o_mdu_valid = HAS_MDU && i_mdu_op;
                if (wait_exit) begin
                    wreq_d      = 1'b1;
                    rreq_d      = trap_pend;   // trap handler needs the RF read port again
                    force_run_d = 1'b1;
                    state_d     = S_RFREQ;
                end
            end
            S_RUN: begin
                o_ctrl_pc_en = cnt_en;
                o_ctrl_trap  = HAS_CSR && (i_e_op || i_new_irq || trap_pend);
                if (cnt_done) begin
                    state_d = S_FETCH;
                    cause_d = CAUSE_NONE;
                    jump_d  = 1'b0;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_FETCH;
            cnt_q       <= '0;
            force_run_q <= 1'b0;
            jump_q      <= 1'b0;
            cause_q     <= CAUSE_NONE;
            rreq_q      <= 1'b0;
            wreq_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            force_run_q <= force_run_d;
            jump_q      <= jump_d;
            cause_q     <= cause_d;
            rreq_q      <= rreq_d;
            wreq_q      <= wreq_d;
            if (cnt_done)
                cnt_q <= '0;
            else if (cnt_en)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_cnt_en      = cnt_en;
    assign o_cnt_done    = cnt_done;
    assign o_cnt         = cnt_q;
    assign o_cnt0        = cnt_en && (cnt_q == '0);
    assign o_rf_rreq     = rreq_q;
    assign o_rf_wreq     = wreq_q;
    assign o_ctrl_jump   = jump_q;
    assign o_trap_cause  = HAS_CSR ? cause_q : CAUSE_NONE;
    // Byte lane of the current beat: bit position cnt*W divided by 8.
    assign o_mem_bytecnt = BW'((AW'(cnt_q) << LW) >> 3);

endmodule

// File: tb/tb_serv_seqctl.sv
// tb_serv_seqctl: directed bench for serv_seqctl with W=2, XLEN=64 (32 beats per pass), MDU enabled.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stall, MDU wait and reset-abort scenarios are driven explicitly.
module tb_serv_seqctl;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_ibus_ack = 0, i_dbus_en = 0, i_mem_misalign = 0, i_dbus_ack = 0;
    logic i_two_stage_op = 0, i_branch_op = 0, i_cond_branch = 0, i_bne_or_bge = 0, i_alu_cmp = 0;
    logic i_ctrl_misalign = 0, i_shift_op = 0, i_sh_done = 0, i_mdu_op = 0, i_mdu_ready = 0;
    logic i_e_op = 0, i_new_irq = 0, i_stall = 0, i_rf_ready = 0;
    logic o_ibus_cyc, o_dbus_cyc, o_mdu_valid, o_rf_rreq, o_rf_wreq;
    logic o_init, o_cnt_en, o_cnt_done, o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap, o_cnt0;
    logic [4:0] o_cnt;
    logic [2:0] o_mem_bytecnt;
    logic [1:0] o_trap_cause;

    int n_tests = 0;
    int n_fail  = 0;

    serv_seqctl #(.W(2), .XLEN(64), .WITH_CSR(1), .ALIGN(0), .MDU(1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_ibus_ack(i_ibus_ack), .o_ibus_cyc(o_ibus_cyc),
        .i_dbus_en(i_dbus_en), .i_mem_misalign(i_mem_misalign),
        .o_dbus_cyc(o_dbus_cyc), .i_dbus_ack(i_dbus_ack),
        .i_two_stage_op(i_two_stage_op), .i_branch_op(i_branch_op),
        .i_cond_branch(i_cond_branch), .i_bne_or_bge(i_bne_or_bge), .i_alu_cmp(i_alu_cmp),
        .i_ctrl_misalign(i_ctrl_misalign), .i_shift_op(i_shift_op), .i_sh_done(i_sh_done),
        .i_mdu_op(i_mdu_op), .i_mdu_ready(i_mdu_ready), .o_mdu_valid(o_mdu_valid),
        .i_e_op(i_e_op), .i_new_irq(i_new_irq), .i_stall(i_stall),
        .o_rf_rreq(o_rf_rreq), .o_rf_wreq(o_rf_wreq), .i_rf_ready(i_rf_ready),
        .o_init(o_init), .o_cnt_en(o_cnt_en), .o_cnt_done(o_cnt_done),
        .o_ctrl_pc_en(o_ctrl_pc_en), .o_ctrl_jump(o_ctrl_jump), .o_ctrl_trap(o_ctrl_trap),
        .o_cnt(o_cnt), .o_cnt0(o_cnt0), .o_mem_bytecnt(o_mem_bytecnt),
        .o_trap_cause(o_trap_cause)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_decode();
        i_dbus_en = 0; i_mem_misalign = 0; i_two_stage_op = 0; i_branch_op = 0;
        i_cond_branch = 0; i_bne_or_bge = 0; i_alu_cmp = 0; i_ctrl_misalign = 0;
        i_shift_op = 0; i_sh_done = 0; i_mdu_op = 0; i_mdu_ready = 0;
        i_e_op = 0; i_new_irq = 0; i_dbus_ack = 0;
    endtask

    // Fetch handshake: ack in FETCH, rreq pulse appears the following cycle.
    task automatic do_fetch(input string tag);
        i_ibus_ack = 1'b1;
        tick();
        i_ibus_ack = 1'b0;
        chk({tag, "_rreq"}, o_rf_rreq, 1);
        chk({tag, "_ibus_off"}, o_ibus_cyc, 0);
    endtask

    task automatic rf_ready_pulse();
        i_rf_ready = 1'b1;
        tick();
        i_rf_ready = 1'b0;
    endtask

    // Ticks until o_cnt_done is seen; returns the number of ticks taken (bounded).
    task automatic wait_done(output int c);
        c = 0;
        while (!o_cnt_done && c < 200) begin
            tick();
            c++;
        end
    endtask

    initial begin
        int c;
        int vcnt;
        int wcnt;

        // Reset state
        tick(); tick();
        chk("rst_ibus_cyc", o_ibus_cyc, 1);
        chk("rst_cnt", o_cnt, 0);
        chk("rst_rreq", o_rf_rreq, 0);
        chk("rst_cnt_en", o_cnt_en, 0);
        chk("rst_cause", o_trap_cause, 0);
        i_rst_n = 1'b1;
        tick();
        chk("rel_ibus_cyc", o_ibus_cyc, 1);

        // ADD: single RUN pass of 32 beats
        clr_decode();
        do_fetch("add");
        rf_ready_pulse();
        chk("add_rreq_clear", o_rf_rreq, 0);
        chk("add_init", o_init, 0);
        chk("add_cnt0", o_cnt0, 1);
        chk("add_pc_en", o_ctrl_pc_en, 1);
        wait_done(c);
        chk("add_beats", c, 31);
        chk("add_last_cnt", o_cnt, 31);
        tick();
        chk("add_back_fetch", o_ibus_cyc, 1);
        chk("add_cnt_wrap", o_cnt, 0);

        // BEQ taken (cmp=1, bne_or_bge=0), aligned target
        clr_decode();
        i_two_stage_op = 1; i_branch_op = 1; i_cond_branch = 1; i_alu_cmp = 1;
        do_fetch("beq");
        rf_ready_pulse();
        chk("beq_init", o_init, 1);
        wait_done(c);
        chk("beq_init_beats", c, 31);
        tick();
        chk("beq_jump_latched", o_ctrl_jump, 1);
        chk("beq_dbus_idle", o_dbus_cyc, 0);
        tick();
        chk("beq_wreq", o_rf_wreq, 1);
        chk("beq_no_rreq", o_rf_rreq, 0);
        rf_ready_pulse();
        chk("beq_run_not_init", o_init, 0);
        chk("beq_wreq_once", o_rf_wreq, 0);
        chk("beq_jump_run", o_ctrl_jump, 1);
        chk("beq_no_trap", o_ctrl_trap, 0);
        chk("beq_cause", o_trap_cause, 0);
        wait_done(c);
        chk("beq_run_beats", c, 31);
        tick();
        chk("beq_jump_cleared", o_ctrl_jump, 0);

        // BNE not taken: cmp=1 with bne_or_bge=1 gives no jump
        clr_decode();
        i_two_stage_op = 1; i_branch_op = 1; i_cond_branch = 1; i_alu_cmp = 1; i_bne_or_bge = 1;
        i_ctrl_misalign = 1;
        do_fetch("bne");
        rf_ready_pulse();
        wait_done(c);
        tick();
        chk("bne_no_jump", o_ctrl_jump, 0);
        chk("bne_no_cause", o_trap_cause, 0);
        tick();
        rf_ready_pulse();
        wait_done(c);
        tick();

        // LW with misaligned address: no dbus request, rreq+wreq together, cause 11
        clr_decode();
        i_two_stage_op = 1; i_dbus_en = 1; i_mem_misalign = 1;
        do_fetch("lw");
        rf_ready_pulse();
        wait_done(c);
        tick();
        chk("lw_cause_wait", o_trap_cause, 3);
        chk("lw_no_dbus", o_dbus_cyc, 0);
        tick();
        chk("lw_wreq", o_rf_wreq, 1);
        chk("lw_rreq", o_rf_rreq, 1);
        rf_ready_pulse();
        chk("lw_trap", o_ctrl_trap, 1);
        chk("lw_cause_run", o_trap_cause, 3);
        wait_done(c);
        tick();
        chk("lw_cause_cleared", o_trap_cause, 0);

        // JAL to a misaligned target: cause 10
        clr_decode();
        i_two_stage_op = 1; i_branch_op = 1; i_ctrl_misalign = 1;
        do_fetch("jal");
        rf_ready_pulse();
        wait_done(c);
        tick();
        chk("jal_cause", o_trap_cause, 2);
        tick();
        chk("jal_rreq", o_rf_rreq, 1);
        rf_ready_pulse();
        chk("jal_trap", o_ctrl_trap, 1);
        wait_done(c);
        tick();

        // Stall for 3 cycles at beat 10; stray ibus ack in RUN ignored
        clr_decode();
        do_fetch("stall");
        rf_ready_pulse();
        repeat (10) tick();
        chk("stall_cnt10", o_cnt, 10);
        chk("stall_bytecnt", o_mem_bytecnt, 2);
        i_stall = 1'b1;
        i_ibus_ack = 1'b1;
        #1;
        chk("stall_cnt_en", o_cnt_en, 0);
        chk("stall_pc_en", o_ctrl_pc_en, 0);
        repeat (3) tick();
        i_ibus_ack = 1'b0;
        chk("stall_cnt_hold", o_cnt, 10);
        chk("stall_ack_ignored", o_rf_rreq, 0);
        i_stall = 1'b0;
        wait_done(c);
        chk("stall_rest_beats", c, 21);
        tick();
        chk("stall_fetch", o_ibus_cyc, 1);

        // MUL: mdu_valid held 40 cycles until ready, then wreq
        clr_decode();
        i_two_stage_op = 1; i_mdu_op = 1;
        do_fetch("mul");
        rf_ready_pulse();
        wait_done(c);
        tick();
        vcnt = 0;
        wcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_mdu_valid) vcnt++;
            if (o_rf_wreq) wcnt++;
            tick();
        end
        chk("mul_valid_held", vcnt, 40);
        chk("mul_no_early_wreq", wcnt, 0);
        i_mdu_ready = 1'b1;
        tick();
        i_mdu_ready = 1'b0;
        chk("mul_wreq", o_rf_wreq, 1);
        chk("mul_valid_drop", o_mdu_valid, 0);
        rf_ready_pulse();
        chk("mul_run", o_ctrl_pc_en, 1);
        wait_done(c);
        chk("mul_run_beats", c, 31);
        tick();

        // Interrupt on a two-stage op: skip INIT, cause 01
        clr_decode();
        i_two_stage_op = 1; i_new_irq = 1;
        do_fetch("irq");
        rf_ready_pulse();
        chk("irq_no_init", o_init, 0);
        chk("irq_cause", o_trap_cause, 1);
        chk("irq_trap", o_ctrl_trap, 1);
        wait_done(c);
        tick();
        clr_decode();

        // Reset at INIT beat 5
        i_two_stage_op = 1;
        do_fetch("rstmid");
        rf_ready_pulse();
        repeat (5) tick();
        chk("rstmid_cnt5", o_cnt, 5);
        i_rst_n = 1'b0;
        #1;
        chk("rstmid_cnt0", o_cnt, 0);
        chk("rstmid_init", o_init, 0);
        chk("rstmid_ibus", o_ibus_cyc, 1);
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("rstmid_rel_ibus", o_ibus_cyc, 1);
        chk("rstmid_rel_cnt", o_cnt, 0);
        chk("rstmid_no_rreq", o_rf_rreq, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
